// File: rtl/reg_file_sweep.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hardwired zero register and write bypass, plus a soft-clear sweep engine.
module reg_file_sweep #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  DROPPED
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  dropped_q, dropped_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  wrEn;
    logic                  sweepEn;
    logic                  zeroWrite;
    logic                  bypassOk;

    // Writes to a hardwired r0 are not real requests: never stored, never reported as dropped.
    assign zeroWrite = (ZERO_REG != 0) && (INADDRESS == '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wrEn      = 1'b0;
        sweepEn   = 1'b0;
        dropped_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CLEAR) begin
                    state_d   = SWEEP;
                    idx_d     = '0;
                    dropped_d = WRITE && !zeroWrite;
                end else begin
                    wrEn = WRITE && !zeroWrite;
                end
            end
            SWEEP: begin
                sweepEn   = 1'b1;
                idx_d     = idx_q + 1'b1;
                dropped_d = WRITE && !zeroWrite;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d == SWEEP);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    // The sweep and a write are mutually exclusive, since writes are only taken in IDLE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else if (sweepEn) begin
            regs_q[idx_q] <= '0;
        end else if (wrEn) begin
            regs_q[INADDRESS] <= IN;
        end
    end

    assign bypassOk = (BYPASS != 0) && WRITE && !busy_q && !CLEAR && !zeroWrite;

    always_comb begin
        OUT1 = regs_q[OUT1ADDRESS];
        OUT2 = regs_q[OUT2ADDRESS];
        if (bypassOk && (INADDRESS == OUT1ADDRESS)) begin
            OUT1 = IN;
        end
        if (bypassOk && (INADDRESS == OUT2ADDRESS)) begin
            OUT2 = IN;
        end
        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end
    end

    assign BUSY    = busy_q;
    assign DROPPED = dropped_q;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Self-checking bench for reg_file_sweep: default, no-bypass and 16x16 zero-register
// instances, with expected values queued at stimulus time and popped at sampling.
module tb_reg_file_sweep;

    logic       clk;
    logic       rstN;
    logic [7:0] in8;
    logic [2:0] inAddr;
    logic       write;
    logic [2:0] o1a, o2a;
    logic       clear;
    logic [7:0] out1, out2, out1Nb, out2Nb;
    logic       busy, dropped, busyNb, droppedNb;

    logic [15:0] zIn;
    logic [3:0]  zAddr, zO1a, zO2a;
    logic        zWrite, zClear;
    logic [15:0] zOut1, zOut2;
    logic        zBusy, zDropped;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t       sbQ[$];
    exp_t       e;
    logic [7:0] model[8];
    int         checks = 0;
    int         errors = 0;

    reg_file_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) dut (
        .CLK(clk), .RESET_N(rstN), .IN(in8), .INADDRESS(inAddr), .WRITE(write),
        .OUT1ADDRESS(o1a), .OUT2ADDRESS(o2a), .OUT1(out1), .OUT2(out2),
        .CLEAR(clear), .BUSY(busy), .DROPPED(dropped)
    );

    reg_file_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) dutNb (
        .CLK(clk), .RESET_N(rstN), .IN(in8), .INADDRESS(inAddr), .WRITE(write),
        .OUT1ADDRESS(o1a), .OUT2ADDRESS(o2a), .OUT1(out1Nb), .OUT2(out2Nb),
        .CLEAR(clear), .BUSY(busyNb), .DROPPED(droppedNb)
    );

    reg_file_sweep #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1), .BYPASS(1)) dutZ (
        .CLK(clk), .RESET_N(rstN), .IN(zIn), .INADDRESS(zAddr), .WRITE(zWrite),
        .OUT1ADDRESS(zO1a), .OUT2ADDRESS(zO2a), .OUT1(zOut1), .OUT2(zOut2),
        .CLEAR(zClear), .BUSY(zBusy), .DROPPED(zDropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void pushExp(string n, logic [15:0] v);
        exp_t x;
        x.name = n;
        x.val  = v;
        sbQ.push_back(x);
    endfunction

    // Stimulus always changes at posedge+1 so combinational reads settle before the next edge.
    task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
        write  = 1'b1;
        inAddr = a;
        in8    = d;
        @(posedge clk); #1;
        write    = 1'b0;
        model[a] = d;
    endtask

    task automatic fillRegs();
        for (int k = 0; k < 8; k++) begin
            writeReg(3'(k), 8'(8'h10 + k));
        end
    endtask

    task automatic waitSweepDone();
        for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sweep_timeout: busy=%b required 0", busy);
        end
        for (int k = 0; k < 8; k++) model[k] = 8'h00;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #3;
        pushExp("reset_busy", 16'h0000);
        pushExp("reset_dropped", 16'h0000);
        pushExp("reset_busy_nb", 16'h0000);
        e = sbQ.pop_front(); checks++;
        if ({15'h0, busy} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, busy, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({15'h0, dropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, dropped, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({15'h0, busyNb | droppedNb | zBusy | zDropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, busyNb, e.val); end
        for (int k = 0; k < 8; k++) begin
            o1a = 3'(k);
            o2a = 3'(7 - k);
            pushExp("reset_reg", 16'h0000);
            #1;
            e = sbQ.pop_front(); checks++;
            if ({8'h00, out1 | out2} !== e.val) begin errors++; $display("[TB] FAIL %s r%0d: got %h/%h required %h", e.name, k, out1, out2, e.val); end
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int k = 0; k < 8; k++) model[k] = 8'h00;
    endtask

    task automatic test_basic_rw();
        writeReg(3'd3, 8'hA5);
        writeReg(3'd5, 8'h3C);
        o1a = 3'd3;
        o2a = 3'd5;
        pushExp("rw_out1_r3", {8'h00, model[3]});
        pushExp("rw_out2_r5", {8'h00, model[5]});
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out2} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out2, e.val); end
        o1a = 3'd7;
        pushExp("rw_out1_r7", 16'h0000);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
    endtask

    task automatic test_bypass();
        writeReg(3'd2, 8'h11);
        write  = 1'b1;
        inAddr = 3'd2;
        in8    = 8'h77;
        o1a    = 3'd2;
        o2a    = 3'd2;
        pushExp("bypass_out1", 16'h0077);
        pushExp("bypass_out2", 16'h0077);
        pushExp("nobypass_out1_before", 16'h0011);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out2} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out2, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1Nb} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1Nb, e.val); end
        @(posedge clk); #1;
        write    = 1'b0;
        model[2] = 8'h77;
        pushExp("nobypass_out1_after", 16'h0077);
        pushExp("bypass_out1_after", 16'h0077);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1Nb} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1Nb, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
    endtask

    task automatic test_sweep();
        fillRegs();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        pushExp("sweep_busy_rise", 16'h0001);
        e = sbQ.pop_front(); checks++;
        if ({15'h0, busy} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, busy, e.val); end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            model[c-1] = 8'h00;
            o1a = 3'(c - 1);
            o2a = (c < 8) ? 3'(c) : 3'd0;
            pushExp("sweep_busy", (c < 8) ? 16'h0001 : 16'h0000);
            pushExp("sweep_swept_reg", {8'h00, model[o1a]});
            pushExp("sweep_pending_reg", {8'h00, model[o2a]});
            #1;
            e = sbQ.pop_front(); checks++;
            if ({15'h0, busy} !== e.val) begin errors++; $display("[TB] FAIL %s c=%0d: got %h required %h", e.name, c, busy, e.val); end
            e = sbQ.pop_front(); checks++;
            if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s r%0d: got %h required %h", e.name, o1a, out1, e.val); end
            e = sbQ.pop_front(); checks++;
            if ({8'h00, out2} !== e.val) begin errors++; $display("[TB] FAIL %s r%0d: got %h required %h", e.name, o2a, out2, e.val); end
        end
        writeReg(3'd1, 8'h5A);
        o1a = 3'd1;
        pushExp("first_write_after_sweep", 16'h005A);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
    endtask

    task automatic test_dropped();
        writeReg(3'd6, 8'h16);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(posedge clk); #1;
        write  = 1'b1;
        inAddr = 3'd6;
        in8    = 8'hEE;
        o1a    = 3'd6;
        @(posedge clk); #1;
        write = 1'b0;
        pushExp("drop_sweep_pulse", 16'h0001);
        pushExp("drop_sweep_r6_kept", 16'h0016);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({15'h0, dropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, dropped, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
        @(posedge clk); #1;
        pushExp("drop_sweep_pulse_end", 16'h0000);
        e = sbQ.pop_front(); checks++;
        if ({15'h0, dropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, dropped, e.val); end
        waitSweepDone();

        writeReg(3'd6, 8'h55);
        clear  = 1'b1;
        write  = 1'b1;
        inAddr = 3'd6;
        in8    = 8'h66;
        o1a    = 3'd6;
        pushExp("drop_clear_no_bypass", 16'h0055);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
        @(posedge clk); #1;
        clear = 1'b0;
        write = 1'b0;
        pushExp("drop_clear_pulse", 16'h0001);
        pushExp("drop_clear_r6_kept", 16'h0055);
        e = sbQ.pop_front(); checks++;
        if ({15'h0, dropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, dropped, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
        @(posedge clk); #1;
        pushExp("drop_clear_pulse_end", 16'h0000);
        e = sbQ.pop_front(); checks++;
        if ({15'h0, dropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, dropped, e.val); end
        waitSweepDone();
    endtask

    task automatic test_zero_reg();
        zWrite = 1'b1;
        zAddr  = 4'd0;
        zIn    = 16'hBEEF;
        zO1a   = 4'd0;
        zO2a   = 4'd0;
        pushExp("zero_no_bypass", 16'h0000);
        #1;
        e = sbQ.pop_front(); checks++;
        if ((zOut1 | zOut2) !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, zOut1, e.val); end
        @(posedge clk); #1;
        zWrite = 1'b0;
        pushExp("zero_after_write", 16'h0000);
        pushExp("zero_no_drop", 16'h0000);
        e = sbQ.pop_front(); checks++;
        if (zOut1 !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, zOut1, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({15'h0, zDropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, zDropped, e.val); end
        zWrite = 1'b1;
        zAddr  = 4'd15;
        zO1a   = 4'd15;
        pushExp("zero_r15_bypass", 16'hBEEF);
        #1;
        e = sbQ.pop_front(); checks++;
        if (zOut1 !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, zOut1, e.val); end
        @(posedge clk); #1;
        zWrite = 1'b0;
        pushExp("zero_r15_stored", 16'hBEEF);
        e = sbQ.pop_front(); checks++;
        if (zOut1 !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, zOut1, e.val); end
    endtask

    task automatic test_async_reset();
        fillRegs();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        #1;
        rstN = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 8'h00;
        pushExp("areset_busy", 16'h0000);
        pushExp("areset_dropped", 16'h0000);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({15'h0, busy} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, busy, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({15'h0, dropped} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, dropped, e.val); end
        for (int k = 0; k < 8; k++) begin
            o1a = 3'(k);
            pushExp("areset_reg", {8'h00, model[k]});
            #1;
            e = sbQ.pop_front(); checks++;
            if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s r%0d: got %h required %h", e.name, k, out1, e.val); end
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        writeReg(3'd2, 8'h42);
        o1a = 3'd2;
        pushExp("areset_write_after", 16'h0042);
        pushExp("areset_busy_after", 16'h0000);
        #1;
        e = sbQ.pop_front(); checks++;
        if ({8'h00, out1} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, out1, e.val); end
        e = sbQ.pop_front(); checks++;
        if ({15'h0, busy} !== e.val) begin errors++; $display("[TB] FAIL %s: got %h required %h", e.name, busy, e.val); end
    endtask

    initial begin
        in8 = '0; inAddr = '0; write = 1'b0; o1a = '0; o2a = '0; clear = 1'b0;
        zIn = '0; zAddr = '0; zWrite = 1'b0; zO1a = '0; zO2a = '0; zClear = 1'b0;
        test_reset();
        test_basic_rw();
        test_bypass();
        test_sweep();
        test_dropped();
        test_zero_reg();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
